// File: rtl/lsu_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the LEGv8 load/store bridge: access-size
//            encodings, bridge state encoding and a size-to-bytes helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access-size encodings carried on req_size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8)
  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    bytes_of = 4'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_req_if / lsu_mem_if
// Purpose  : Bus bundles around the load/store bridge.
//            lsu_req_if : datapath request/response channel
//                         master = datapath, slave = bridge
//            lsu_mem_if : synchronous RAM channel
//                         master = bridge, slave = RAM
// Ports    : none (interfaces); widths follow DATA_W / ADDR_W
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_req_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

interface lsu_mem_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  localparam int OFF_W = $clog2(DATA_W/8);

  logic                    mem_en;
  logic                    mem_we;
  logic [DATA_W/8-1:0]     mem_be;
  logic [ADDR_W-OFF_W-1:0] mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_ack;

  modport master (
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_bridge_lane_extract.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_extract
// Purpose  : Combinational load-lane extraction. Shifts the RAM word down by
//            the byte offset, keeps the bytes of the access size and sign- or
//            zero-extends the result to the full word.
// Ports    : word_i   - RAM read word
//            off_i    - byte offset inside the word
//            size_i   - access size (lsu_pkg SZ_*)
//            signed_i - 1 = sign-extend
//            result_o - extended load result
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_extract
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 64,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] w_shifted;
  int                w_nbits;
  logic              w_msb;

  always_comb begin
    w_shifted = word_i >> {off_i, 3'b000};

    w_nbits = DATA_W;
    case (size_i)
      SZ_B: w_nbits = 8;
      SZ_H: w_nbits = 16;
      SZ_W: w_nbits = 32;
      SZ_D: w_nbits = 64;
    endcase
    // A double on a 32-bit build is faulted upstream; clamp keeps indexing legal
    if (w_nbits > DATA_W) w_nbits = DATA_W;

    w_msb = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == w_nbits - 1) w_msb = w_shifted[i];
    end

    result_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      result_o[i] = (i < w_nbits) ? w_shifted[i] : (signed_i & w_msb);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_bridge
// Purpose  : Load/store bridge between the LEGv8 memory-access stage and a
//            word-wide synchronous RAM. Valid/ready request, one-cycle
//            registered response, byte-lane steering, load extension and a
//            wait-state handshake with timeout fault.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-high reset
//            req   - lsu_req_if.slave  (request / response channel)
//            mem   - lsu_mem_if.master (RAM channel)
// Config   : LSU_ALIGN_CHECK_EN - when defined, misaligned requests fault
//            immediately; otherwise the byte offset is aligned down.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_bridge #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire       clock,
  input  wire       reset,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);
  import lsu_pkg::*;

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Registered state and outputs
  state_t            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_fault_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [WA_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [CNT_W-1:0]  cnt_q;

  // Values decoded from the incoming request
  logic [OFF_W-1:0]  raw_off_d;
  logic [OFF_W-1:0]  align_mask_d;
  logic [OFF_W-1:0]  off_d;
  logic              size_fault_d;
  logic              imm_fault_d;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] lane_d;

  always_comb begin
    raw_off_d    = req.req_addr[OFF_W-1:0];
    // Low offset bits that must be zero for a naturally aligned access
    align_mask_d = OFF_W'(bytes_of(req.req_size) - 4'd1);
    size_fault_d = ({1'b0, bytes_of(req.req_size)} > 5'(BE_W));
`ifdef LSU_ALIGN_CHECK_EN
    off_d        = raw_off_d;
    imm_fault_d  = size_fault_d | (|(raw_off_d & align_mask_d));
`else
    off_d        = raw_off_d & ~align_mask_d;
    imm_fault_d  = size_fault_d;
`endif
    be_d    = BE_W'((16'd1 << bytes_of(req.req_size)) - 16'd1) << off_d;
    wdata_d = req.req_wdata << {off_d, 3'b000};
  end

  lsu_lane_extract #(
    .DATA_W (DATA_W)
  ) u_lane_extract (
    .word_i   (mem.mem_rdata),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .result_o (lane_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      off_q        <= '0;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req.req_valid) begin
            off_q       <= off_d;
            size_q      <= req.req_size;
            signed_q    <= req.req_signed;
            req_ready_q <= 1'b0;
            if (imm_fault_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= ST_ACCESS;
              mem_en_q    <= 1'b1;
              mem_we_q    <= req.req_write;
              mem_be_q    <= be_d;
              mem_addr_q  <= req.req_addr[ADDR_W-1:OFF_W];
              mem_wdata_q <= wdata_d;
              cnt_q       <= '0;
            end
          end
        end

        ST_ACCESS: begin
          // Timeout is tested first so it wins over an ack in the same cycle
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b1;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
          end else if (mem.mem_ack) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= mem_we_q ? '0 : lane_d;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= '0;
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req.req_ready  = req_ready_q;
  assign req.resp_valid = resp_valid_q;
  assign req.resp_fault = resp_fault_q;
  assign req.resp_rdata = resp_rdata_q;
  assign mem.mem_en     = mem_en_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_be     = mem_be_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_bridge
// Purpose  : Directed testbench for lsu_mem_bridge (64-bit instance plus a
//            32-bit instance for the oversize-access fault). Expected RAM
//            accesses and responses are queued when a request is issued and
//            popped by independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_bridge;
  import lsu_pkg::*;

  localparam int TO = 255;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lsu_req_if #(.DATA_W(64), .ADDR_W(32)) rq ();
  lsu_mem_if #(.DATA_W(64), .ADDR_W(32)) mm ();
  lsu_req_if #(.DATA_W(32), .ADDR_W(32)) rq32 ();
  lsu_mem_if #(.DATA_W(32), .ADDR_W(32)) mm32 ();

  lsu_mem_bridge #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .req   (rq),
    .mem   (mm)
  );

  lsu_mem_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut32 (
    .clock (clock),
    .reset (reset),
    .req   (rq32),
    .mem   (mm32)
  );

  typedef struct packed {
    logic [28:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wd;
  } mexp_t;

  typedef struct packed {
    logic        fault;
    logic [63:0] rdata;
  } rexp_t;

  mexp_t       mem_q[$];
  rexp_t       resp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = -1;
  logic [63:0] ram_rdata = '0;
  bit          force_ack = 1'b0;
  int          rsp_cnt = 0;
  logic        mon_prev_en = 1'b0;
  logic        mon_prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: acks the ack_delay-th cycle (0-based) of an access; -1 = never
  initial begin
    mm.mem_ack   = 1'b0;
    mm.mem_rdata = '0;
    forever begin
      @(negedge clock);
      mm.mem_ack   = force_ack;
      mm.mem_rdata = force_ack ? 64'hDEAD_DEAD_DEAD_DEAD : '0;
      if (mm.mem_en === 1'b1) begin
        if (ack_delay >= 0 && rsp_cnt == ack_delay) begin
          mm.mem_ack   = 1'b1;
          mm.mem_rdata = ram_rdata;
        end
        rsp_cnt++;
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // RAM-side monitor: checks the request presented when mem_en rises
  initial begin
    forever begin
      @(negedge clock);
      if (mm.mem_en === 1'b1 && mon_prev_en !== 1'b1) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got access at word %h expected no access", mm.mem_addr);
        end else begin
          mexp_t e;
          e = mem_q.pop_front();
          check("mem_addr", 64'(mm.mem_addr), 64'(e.addr));
          check("mem_be", 64'(mm.mem_be), 64'(e.be));
          check("mem_we", 64'(mm.mem_we), 64'(e.we));
          check("mem_wdata", mm.mem_wdata, e.wd);
        end
      end
      mon_prev_en = mm.mem_en;
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clock);
      if (rq.resp_valid === 1'b1) begin
        if (mon_prev_valid === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL resp_width: got resp_valid 2+ cycles expected 1");
        end
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got response expected none");
        end else begin
          rexp_t r;
          r = resp_q.pop_front();
          check("resp_fault", 64'(rq.resp_fault), 64'(r.fault));
          check("resp_rdata", rq.resp_rdata, r.rdata);
          check("ready_in_resp", 64'(rq.req_ready), 64'd0);
        end
      end
      mon_prev_valid = rq.resp_valid;
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clock);
    while (rq.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) check("ready_wait", 64'(rq.req_ready), 64'd1);
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd, input int dly, input bit acc,
                        input logic [28:0] eaddr, input logic [7:0] ebe,
                        input logic [63:0] ewd, input bit efault,
                        input logic [63:0] erd);
    int  lat;
    int  exp_lat;
    bit  done;
    wait_ready();
    ram_rdata = rd;
    ack_delay = dly;
    if (acc) mem_q.push_back('{addr: eaddr, be: ebe, we: wr, wd: ewd});
    resp_q.push_back('{fault: efault, rdata: erd});
    rq.req_valid  = 1'b1;
    rq.req_write  = wr;
    rq.req_size   = sz;
    rq.req_signed = sg;
    rq.req_addr   = addr;
    rq.req_wdata  = wd;
    @(posedge clock);
    #1;
    rq.req_valid = 1'b0;
    exp_lat = !acc ? 1 : ((dly < 0) ? TO + 1 : dly + 2);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < TO + 20) begin
      @(negedge clock);
      lat++;
      if (rq.resp_valid === 1'b1) done = 1'b1;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_size = SZ_B;
    rq.req_signed = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
    rq32.req_valid = 1'b0; rq32.req_write = 1'b0; rq32.req_size = SZ_B;
    rq32.req_signed = 1'b0; rq32.req_addr = '0; rq32.req_wdata = '0;
    mm32.mem_ack = 1'b0; mm32.mem_rdata = '0;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 64'(rq.req_ready), 64'd1);
    check("rst_resp_valid", 64'(rq.resp_valid), 64'd0);
    check("rst_resp_fault", 64'(rq.resp_fault), 64'd0);
    check("rst_resp_rdata", rq.resp_rdata, 64'd0);
    check("rst_mem_en", 64'(mm.mem_en), 64'd0);
    check("rst_mem_we", 64'(mm.mem_we), 64'd0);
    check("rst_mem_be", 64'(mm.mem_be), 64'd0);
    check("rst_mem_addr", 64'(mm.mem_addr), 64'd0);
    check("rst_mem_wdata", mm.mem_wdata, 64'd0);
    reset = 1'b0;

    // wr sz sg addr wdata rdata dly acc eaddr ebe ewd efault erd
    do_req(1, SZ_D, 0, 32'h18, 64'h1122_3344_5566_7788, 64'h0, 2,
           1, 29'h3, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'h0);
    do_req(0, SZ_B, 1, 32'h1D, 64'h0, 64'h0000_80FF_0000_0000, 0,
           1, 29'h3, 8'h20, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(0, SZ_B, 0, 32'h1D, 64'h0, 64'h0000_80FF_0000_0000, 1,
           1, 29'h3, 8'h20, 64'h0, 0, 64'h80);
    do_req(1, SZ_H, 0, 32'h06, 64'hBEEF, 64'h0, 0,
           1, 29'h0, 8'hC0, 64'hBEEF_0000_0000_0000, 0, 64'h0);
`ifdef LSU_ALIGN_CHECK_EN
    do_req(0, SZ_W, 1, 32'h02, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
           0, 29'h0, 8'h00, 64'h0, 1, 64'h0);
`else
    do_req(0, SZ_W, 1, 32'h02, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
           1, 29'h0, 8'h0F, 64'h0, 0, 64'hFFFF_FFFF_89AB_CDEF);
`endif
    do_req(0, SZ_H, 1, 32'h0A, 64'h0, 64'h0000_0000_7FFF_0000, 3,
           1, 29'h1, 8'h0C, 64'h0, 0, 64'h7FFF);
    do_req(0, SZ_W, 0, 32'h14, 64'h0, 64'hDEAD_BEEF_0000_0000, 0,
           1, 29'h2, 8'hF0, 64'h0, 0, 64'hDEAD_BEEF);
    do_req(1, SZ_B, 0, 32'h07, 64'hAB, 64'h0, 0,
           1, 29'h0, 8'h80, 64'hAB00_0000_0000_0000, 0, 64'h0);
    do_req(0, SZ_D, 1, 32'h20, 64'h0, 64'h8000_0000_0000_0001, 0,
           1, 29'h4, 8'hFF, 64'h0, 0, 64'h8000_0000_0000_0001);

    // No ack: timeout fault, then a late ack must be ignored
    do_req(0, SZ_D, 0, 32'h08, 64'h0, 64'h0, -1,
           1, 29'h1, 8'hFF, 64'h0, 1, 64'h0);
    check("timeout_mem_en", 64'(mm.mem_en), 64'd0);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("late_ack_ignored", 64'(rq.resp_valid), 64'd0);
    end
    force_ack = 1'b0;
    do_req(0, SZ_H, 0, 32'h3E, 64'h0, 64'hFFEE_0000_0000_0000, 0,
           1, 29'h7, 8'hC0, 64'h0, 0, 64'hFFEE);

    // Reset in the middle of an access
    wait_ready();
    ack_delay = -1;
    mem_q.push_back('{addr: 29'h2, be: 8'hFF, we: 1'b0, wd: 64'h0});
    rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_size = SZ_D;
    rq.req_signed = 1'b0; rq.req_addr = 32'h10; rq.req_wdata = '0;
    @(posedge clock);
    #1;
    rq.req_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("mem_en_before_reset", 64'(mm.mem_en), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mem_en_async_drop", 64'(mm.mem_en), 64'd0);
    check("resp_valid_in_reset", 64'(rq.resp_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("no_resp_after_reset", 64'(rq.resp_valid), 64'd0);
    end
    check("ready_after_reset", 64'(rq.req_ready), 64'd1);

    // 32-bit instance: double access is an oversize fault, no RAM access
    @(negedge clock);
    rq32.req_valid = 1'b1; rq32.req_write = 1'b0; rq32.req_size = SZ_D;
    rq32.req_addr = 32'h0;
    @(posedge clock);
    #1;
    rq32.req_valid = 1'b0;
    @(negedge clock);
    check("d32_resp_valid", 64'(rq32.resp_valid), 64'd1);
    check("d32_resp_fault", 64'(rq32.resp_fault), 64'd1);
    check("d32_resp_rdata", 64'(rq32.resp_rdata), 64'd0);
    check("d32_mem_en", 64'(mm32.mem_en), 64'd0);
    @(negedge clock);
    check("d32_resp_done", 64'(rq32.resp_valid), 64'd0);
    check("d32_ready", 64'(rq32.req_ready), 64'd1);

    repeat (2) @(negedge clock);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
Parametrised load/store bridge between the LEGv8 datapath and a word-wide synchronous RAM. It replaces the shared tri-state data bus and bare mem_read/mem_write/size strobes with a valid/ready request, a registered response, byte-lane steering, sign/zero extension and a wait-state/timeout handshake. It sits between the datapath's memory-access stage and data memory.

Parameters:
DATA_W, 64, datapath and RAM word width in bits (32 or 64)
ADDR_W, 32, byte-address width
TIMEOUT_CYCLES, 255, cycles in ACCESS without mem_ack before a fault response (must be at least 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  bridge accepts request (IDLE only)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 double
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-justified
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DATA_W  load result, extended; 0 for stores and faults
resp_fault  out  1  qualifies resp_valid: size, alignment or timeout fault
mem_en  out  1  RAM access strobe, held until mem_ack
mem_we  out  1  RAM write
mem_be  out  DATA_W/8  byte enables
mem_addr  out  ADDR_W-log2(DATA_W/8)  word address
mem_wdata  out  DATA_W  lane-steered store data
mem_rdata  in  DATA_W  RAM read word, valid when mem_ack=1
mem_ack  in  1  RAM completes access this cycle

Behaviour:
- Reset (async): state=IDLE; req_ready=1; resp_valid=0, resp_fault=0, resp_rdata=0; mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; timeout counter=0. Reset mid-ACCESS drops mem_en immediately. The in-flight request is lost without a response.
- FSM IDLE -> ACCESS -> RESP -> IDLE. IDLE -> RESP directly on an immediate fault.
- IDLE: req_ready=1. On req_valid=1, capture the request.
  - Size fault: (1<<req_size) > DATA_W/8. Go to RESP with fault; no mem_en.
  - Otherwise go to ACCESS.
- ACCESS: all mem_* outputs are registered and held constant.
  - mem_addr = req_addr >> log2(DATA_W/8).
  - off = low byte-offset bits of req_addr.
  - mem_be = ((1<<(1<<size))-1) << off.
  - mem_wdata = req_wdata << (8*off).
  - mem_we = req_write.
  - Counter increments each cycle. On mem_ack, latch the read lane and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES before mem_ack, drop mem_en and go to RESP with fault.
  - mem_ack outside ACCESS is ignored.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
  - Load result = (mem_rdata >> 8*off) masked to the size, then sign-extended if req_signed, else zero-extended.
  - Minimum occupancy is 3 cycles per request with a 1-cycle RAM ack; no back-to-back pipelining.
- mem_ack in the first ACCESS cycle is legal.
- A timeout fault takes precedence over a simultaneous mem_ack.
- Misalignment (off not a multiple of the access size) is handled per the feature below.

Optional Feature:
Macro: LSU_ALIGN_CHECK_EN
- Defined: a misaligned request produces an immediate fault response (IDLE -> RESP, resp_fault=1, no RAM access).
- Undefined: off is forced aligned down (low log2(size) bits cleared). No alignment fault; only size and timeout faults exist.

Decomposition:
- Package lsu_pkg: size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D), state enum (ST_IDLE, ST_ACCESS, ST_RESP), and function bytes_of(size).
- One natural sub-module: lsu_lane_extract (combinational). Takes word, offset, size and signed; returns the extended result.
- Write steering stays inline.

Test Plan:
- Store double: addr 0x18, wdata 0x1122334455667788, ack after 2 cycles -> mem_addr=3, mem_be=0xFF, mem_we=1; resp_valid 1 cycle, fault=0.
- Signed byte load: addr 0x1D, mem_rdata 0x0000_80FF_0000_0000 -> mem_be=0x20; resp_rdata=0xFFFF_FFFF_FFFF_FF80. Unsigned -> 0x80.
- Half store: addr 0x06, wdata 0xBEEF -> mem_be=0xC0, mem_wdata=0xBEEF_0000_0000_0000.
- No ack for 255 cycles -> mem_en drops; resp_valid=1, resp_fault=1, resp_rdata=0. A late ack is ignored.
- Word load at addr 0x02:
  - With LSU_ALIGN_CHECK_EN: fault, mem_en never high.
  - Without: mem_be=0x0F.
- Reset asserted mid-ACCESS -> mem_en=0 asynchronously, no resp_valid, req_ready=1 after release. DATA_W=32 with size 11 -> immediate fault.
